// File: rtl/buffer_requester_if.sv
// Handshake bundle between the input buffer, its upstream source and the output-port allocator.
// The master modport is the buffer's view; slave is the upstream/allocator side.
interface buffer_requester_if #(
  parameter int FLIT_W = 32
);
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic              req;
  logic [2:0]        dport;
  logic              grant;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;

  modport master (
    input  in_flit, in_valid, grant,
    output in_ready, req, dport, out_flit, out_valid
  );

  modport slave (
    output in_flit, in_valid, grant,
    input  in_ready, req, dport, out_flit, out_valid
  );
endinterface

// File: rtl/buffer_requester.sv
// Router input buffer: circular flit FIFO whose head requests an XY-routed output port
// from the allocator and is popped by a same-cycle grant.
module buffer_requester #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 32,
  parameter int X_ADDR = 0,
  parameter int Y_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  buffer_requester_if.master     bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [7:0]             wait_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] X_A = 2'(X_ADDR);
  localparam logic [1:0] Y_A = 2'(Y_ADDR);

  typedef enum logic {IDLE, REQUEST} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        wait_q, wait_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] head;
  logic              push;
  logic              pop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Dimension-order routing: resolve X first, then Y; matching both means local delivery.
  function automatic logic [2:0] xy_route(input logic [1:0] dx, input logic [1:0] dy);
    if (dx > X_A)      return 3'd2;
    else if (dx < X_A) return 3'd4;
    else if (dy > Y_A) return 3'd1;
    else if (dy < Y_A) return 3'd3;
    else               return 3'd0;
  endfunction

  assign head         = mem_q[rd_ptr_q];
  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.req && bus.grant;
  assign occupancy    = count_q;
  assign wait_cycles  = wait_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = REQUEST;
      REQUEST: if (pop && !push && (count_q == CNT_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Head stays put until popped, so req/dport are stable while waiting for grant.
  always_comb begin
    bus.req       = 1'b0;
    bus.dport     = 3'd0;
    bus.out_valid = 1'b0;
    bus.out_flit  = '0;
    if (state_q == REQUEST) begin
      bus.req       = 1'b1;
      bus.dport     = xy_route(head[3:2], head[1:0]);
      bus.out_valid = bus.grant;
      if (bus.grant) bus.out_flit = head;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wait_d   = (pop || (state_q == IDLE)) ? 8'd0 : sat_inc(wait_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

  // Flit storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_flit;
  end

endmodule

// File: tb/tb_buffer_requester.sv
// Self-checking bench for buffer_requester: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the buffer.
module tb_buffer_requester;

  localparam int DEPTH = 4;
  localparam int XA    = 1;
  localparam int YA    = 1;

  logic       clk;
  logic       rst;
  logic [2:0] occupancy;
  logic [7:0] wait_cycles;
  int         n_vec;
  int         n_err;

  logic [31:0] mq[$];
  int          wm;

  buffer_requester_if #(.FLIT_W(32)) bus ();

  buffer_requester #(.DEPTH(DEPTH), .FLIT_W(32), .X_ADDR(XA), .Y_ADDR(YA)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .occupancy   (occupancy),
    .wait_cycles (wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_route(input logic [31:0] f);
    int dx, dy;
    dx = int'(f[3:2]);
    dy = int'(f[1:0]);
    if (dx > XA) return 3'd2;
    if (dx < XA) return 3'd4;
    if (dy > YA) return 3'd1;
    if (dy < YA) return 3'd3;
    return 3'd0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] f, input logic g);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_flit  = f;
    bus.grant    = g;
    #1;
  endtask

  // Reference model update for the edge that ends the current cycle.
  task automatic advance();
    bit pu, po;
    pu = bus.in_valid && (mq.size() < DEPTH);
    po = (mq.size() != 0) && bus.grant;
    if (po) begin
      mq.delete(0);
      wm = 0;
    end else if (mq.size() != 0) begin
      wm = (wm < 255) ? wm + 1 : 255;
    end else begin
      wm = 0;
    end
    if (pu) mq.push_back(bus.in_flit);
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_flit  = '0;
    bus.grant    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0h want=0", bus.req); end
    n_vec++; if (bus.dport !== 3'd0) begin n_err++; $display("FAIL reset_dport got=%0h want=0", bus.dport); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0h want=0", bus.out_valid); end
    n_vec++; if (bus.out_flit !== 32'h0) begin n_err++; $display("FAIL reset_out_flit got=%0h want=0", bus.out_flit); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0h want=1", bus.in_ready); end
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy got=%0h want=0", occupancy); end
    n_vec++; if (wait_cycles !== 8'd0) begin n_err++; $display("FAIL reset_wait got=%0h want=0", wait_cycles); end
    rst = 1'b1;
    mq.delete();
    wm = 0;
    @(posedge clk);
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0000000D, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_no_early_pop got=%0h want=0", bus.out_valid); end
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL single_req_before got=%0h want=0", bus.req); end
    advance();
    drive(1'b0, 32'h0, 1'b1);
    n_vec++; if (bus.req !== 1'b1) begin n_err++; $display("FAIL single_req got=%0h want=1", bus.req); end
    n_vec++; if (bus.dport !== 3'd2) begin n_err++; $display("FAIL single_dport got=%0h want=2", bus.dport); end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got=%0h want=1", bus.out_valid); end
    n_vec++; if (bus.out_flit !== 32'h0000000D) begin n_err++; $display("FAIL single_out_flit got=%0h want=d", bus.out_flit); end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL single_occ_after got=%0h want=0", occupancy); end
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL single_req_after got=%0h want=0", bus.req); end
    n_vec++; if (bus.out_flit !== 32'h0) begin n_err++; $display("FAIL single_flit_idle got=%0h want=0", bus.out_flit); end
    advance();
  endtask

  task automatic test_xy_order();
    logic [31:0] flits [4];
    logic [2:0]  exp_dp [4];
    flits[0] = 32'h5; flits[1] = 32'h1; flits[2] = 32'h7; flits[3] = 32'h4;
    exp_dp[0] = 3'd0; exp_dp[1] = 3'd4; exp_dp[2] = 3'd1; exp_dp[3] = 3'd3;
    drive(1'b1, flits[0], 1'b1);
    advance();
    for (int i = 1; i <= 4; i++) begin
      drive(i < 4, (i < 4) ? flits[i % 4] : 32'h0, 1'b1);
      n_vec++; if (bus.dport !== exp_dp[i-1]) begin n_err++; $display("FAIL xy_dport[%0d] got=%0h want=%0h", i-1, bus.dport, exp_dp[i-1]); end
      n_vec++; if (bus.out_flit !== flits[i-1]) begin n_err++; $display("FAIL xy_flit[%0d] got=%0h want=%0h", i-1, bus.out_flit, flits[i-1]); end
      advance();
    end
    drive(1'b0, 32'h0, 1'b0);
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL xy_drained got=%0h want=0", occupancy); end
    advance();
  endtask

  task automatic test_full_saturate();
    int exp_w, exp_o;
    for (int k = 0; k <= 270; k++) begin
      drive(k < 6, 32'h10 + 32'(k), 1'b0);
      exp_w = (k == 0) ? 0 : ((k - 1 > 255) ? 255 : k - 1);
      exp_o = (k > 4) ? 4 : k;
      n_vec++; if (bus.in_ready !== (k < 4)) begin n_err++; $display("FAIL full_in_ready[%0d] got=%0h want=%0h", k, bus.in_ready, (k < 4)); end
      n_vec++; if (int'(occupancy) != exp_o) begin n_err++; $display("FAIL full_occ[%0d] got=%0d want=%0d", k, occupancy, exp_o); end
      n_vec++; if (int'(wait_cycles) != exp_w) begin n_err++; $display("FAIL sat_wait[%0d] got=%0d want=%0d", k, wait_cycles, exp_w); end
      advance();
    end
  endtask

  task automatic test_full_pop();
    drive(1'b1, 32'hEE, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL fullpop_valid got=%0h want=1", bus.out_valid); end
    n_vec++; if (bus.out_flit !== 32'h10) begin n_err++; $display("FAIL fullpop_flit got=%0h want=10", bus.out_flit); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fullpop_ready_now got=%0h want=0", bus.in_ready); end
    advance();
    drive(1'b0, 32'h0, 1'b0);
    n_vec++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL fullpop_occ got=%0d want=3", occupancy); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fullpop_ready_next got=%0h want=1", bus.in_ready); end
    n_vec++; if (wait_cycles !== 8'd0) begin n_err++; $display("FAIL fullpop_wait_clear got=%0d want=0", wait_cycles); end
    advance();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_vec++; if (bus.out_flit !== 32'h10 + 32'(i)) begin n_err++; $display("FAIL drain_flit[%0d] got=%0h want=%0h", i, bus.out_flit, 32'h10 + 32'(i)); end
      advance();
    end
    drive(1'b0, 32'h0, 1'b0);
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL drain_req got=%0h want=0", bus.req); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'hA1, 1'b0); advance();
    drive(1'b1, 32'hA2, 1'b0); advance();
    drive(1'b0, 32'h0, 1'b0);
    n_vec++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL midrst_occ_before got=%0d want=2", occupancy); end
    advance();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL midrst_req got=%0h want=0", bus.req); end
    n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL midrst_occ got=%0d want=0", occupancy); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%0h want=1", bus.in_ready); end
    #1 rst = 1'b1;
    mq.delete();
    wm = 0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_out[%0d] got=%0h want=0", i, bus.out_valid); end
      advance();
    end
  endtask

  task automatic test_grant_empty();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL empty_grant_valid[%0d] got=%0h want=0", i, bus.out_valid); end
      n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL empty_grant_occ[%0d] got=%0d want=0", i, occupancy); end
      n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL empty_grant_req[%0d] got=%0h want=0", i, bus.req); end
      advance();
    end
  endtask

  task automatic test_random();
    logic        v, g, e_req, e_ov;
    logic [2:0]  e_dp;
    logic [31:0] e_of, f;
    for (int c = 0; c < 3000; c++) begin
      v = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      g = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = $urandom;
      drive(v, f, g);
      e_req = (mq.size() != 0);
      e_dp  = e_req ? ref_route(mq[0]) : 3'd0;
      e_ov  = e_req && g;
      e_of  = e_ov ? mq[0] : 32'h0;
      n_vec++; if (bus.in_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_in_ready[%0d] got=%0h want=%0h", c, bus.in_ready, (mq.size() < DEPTH)); end
      n_vec++; if (bus.req !== e_req) begin n_err++; $display("FAIL rnd_req[%0d] got=%0h want=%0h", c, bus.req, e_req); end
      n_vec++; if (bus.dport !== e_dp) begin n_err++; $display("FAIL rnd_dport[%0d] got=%0h want=%0h", c, bus.dport, e_dp); end
      n_vec++; if (bus.out_valid !== e_ov) begin n_err++; $display("FAIL rnd_out_valid[%0d] got=%0h want=%0h", c, bus.out_valid, e_ov); end
      n_vec++; if (bus.out_flit !== e_of) begin n_err++; $display("FAIL rnd_out_flit[%0d] got=%0h want=%0h", c, bus.out_flit, e_of); end
      n_vec++; if (int'(occupancy) != mq.size()) begin n_err++; $display("FAIL rnd_occ[%0d] got=%0d want=%0d", c, occupancy, mq.size()); end
      n_vec++; if (int'(wait_cycles) != wm) begin n_err++; $display("FAIL rnd_wait[%0d] got=%0d want=%0d", c, wait_cycles, wm); end
      advance();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wm    = 0;
    test_reset();
    test_single();
    test_xy_order();
    test_full_saturate();
    test_full_pop();
    test_reset_mid();
    test_grant_empty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
